// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with frame debounce and a valid/ack output.
// Define KEYPAD_FIFO_EN to replace the single holding register with a 4-entry FIFO.
//
// state       | meaning
// S_IDLE      | no key accepted, waiting for a frame candidate
// S_DEB_PRESS | same candidate seen for r_cnt consecutive frames
// S_HELD      | press reported, waiting for an empty frame
// S_DEB_REL   | empty frames seen r_cnt times since the key was held
module keypad_scan #(
    parameter logic [15:0] SCAN_DIV        = 16'd1000,
    parameter int          DEBOUNCE_FRAMES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_kp_col,
    input  logic       i_key_ack,
    output logic [3:0] o_kp_row,
    output logic [3:0] o_key_code,
    output logic       o_key_valid,
    output logic       o_overrun
);

    localparam logic [15:0] SLOT_LAST = SCAN_DIV - 16'd1;
    localparam logic [3:0]  DEB_N     = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DEB_PRESS = 2'd1,
        S_HELD      = 2'd2,
        S_DEB_REL   = 2'd3
    } state_t;

    logic [3:0]  r_col_s1;
    logic [3:0]  r_col_s2;
    logic [15:0] r_slot_cnt;
    logic [1:0]  r_row;
    logic        r_found;
    logic [3:0]  r_found_code;
    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cand;
    logic [3:0]  w_cand_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [3:0]  w_cnt_inc;

    logic        w_slot_last;
    logic        w_frame_end;
    logic [3:0]  w_col_hit;
    logic        w_row_any;
    logic [1:0]  w_row_col;
    logic        w_cand_valid;
    logic [3:0]  w_cand_code;
    logic        w_event;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col_s1 <= 4'hF;
            r_col_s2 <= 4'hF;
        end else begin
            r_col_s1 <= i_kp_col;
            r_col_s2 <= r_col_s1;
        end
    end

    assign w_slot_last = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end = w_slot_last && (r_row == 2'd3);
    assign o_kp_row    = ~(4'b0001 << r_row);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_slot_cnt <= '0;
            r_row      <= '0;
        end else if (w_slot_last) begin
            r_slot_cnt <= '0;
            r_row      <= r_row + 2'd1;
        end else begin
            r_slot_cnt <= r_slot_cnt + 16'd1;
        end
    end

    // Columns are active-low; lowest pressed column of the current row wins.
    assign w_col_hit = ~r_col_s2;
    assign w_row_any = |w_col_hit;

    always_comb begin
        w_row_col = '0;
        for (int c = 3; c >= 0; c--) begin
            if (w_col_hit[c]) w_row_col = 2'(c);
        end
    end

    // Earlier rows already found a key take priority over the row-3 sample.
    assign w_cand_valid = r_found || w_row_any;
    assign w_cand_code  = r_found ? r_found_code : {r_row, w_row_col};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_found      <= 1'b0;
            r_found_code <= '0;
        end else if (w_slot_last) begin
            if (r_row == 2'd3) begin
                r_found <= 1'b0;
            end else if (!r_found && w_row_any) begin
                r_found      <= 1'b1;
                r_found_code <= {r_row, w_row_col};
            end
        end
    end

    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cand  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cand  <= w_cand_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_event     = 1'b0;
        if (w_frame_end) begin
            case (r_state)
                S_IDLE: begin
                    if (w_cand_valid) begin
                        w_cand_nxt = w_cand_code;
                        if (DEB_N <= 4'd1) begin
                            w_event     = 1'b1;
                            w_state_nxt = S_HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_DEB_PRESS;
                            w_cnt_nxt   = 4'd1;
                        end
                    end
                end
                S_DEB_PRESS: begin
                    if (w_cand_valid && (w_cand_code == r_cand)) begin
                        if (w_cnt_inc >= DEB_N) begin
                            w_event     = 1'b1;
                            w_state_nxt = S_HELD;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end
                end
                S_HELD: begin
                    if (!w_cand_valid) begin
                        if (DEB_N <= 4'd1) begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_state_nxt = S_DEB_REL;
                            w_cnt_nxt   = 4'd1;
                        end
                    end
                end
                S_DEB_REL: begin
                    if (w_cand_valid) begin
                        w_state_nxt = S_HELD;
                        w_cnt_nxt   = '0;
                    end else if (w_cnt_inc >= DEB_N) begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic [3:0] r_fifo [4];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [2:0] r_count;
    logic       w_full;
    logic       w_pop;
    logic       w_push;

    // A pop on an empty FIFO is not a pop, so a same-cycle push still lands.
    assign w_full = (r_count == 3'd4);
    assign w_pop  = i_key_ack && (r_count != 3'd0);
    assign w_push = w_event && (!w_full || w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) r_fifo[i] <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_cand_code;
                r_wr_ptr         <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_event && w_full && !w_pop) o_overrun <= 1'b1;
        end
    end

    assign o_key_code  = r_fifo[r_rd_ptr];
    assign o_key_valid = (r_count != 3'd0);
`else
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_key_code  <= '0;
            o_key_valid <= 1'b0;
            o_overrun   <= 1'b0;
        end else if (w_event) begin
            if (!o_key_valid || i_key_ack) begin
                o_key_code  <= w_cand_code;
                o_key_valid <= 1'b1;
            end else begin
                o_overrun <= 1'b1;
            end
        end else if (i_key_ack) begin
            o_key_valid <= 1'b0;
        end
    end
`endif

endmodule
